// File: rtl/axis_width_packer_pkg.sv
// axis_width_packer_pkg
// Shared definitions for the AXI4-Stream width packer: default widths,
// the derived narrow-to-wide lane ratio, lane counter width, FSM state
// encoding and constant helper functions used for elaboration checks.
// No ports (package).
package axis_width_packer_pkg;

   localparam int C_S_AXIS_DATA_WIDTH_DFLT  = 64;
   localparam int C_M_AXIS_DATA_WIDTH_DFLT  = 256;
   localparam int C_S_AXIS_TUSER_WIDTH_DFLT = 128;
   localparam int C_M_AXIS_TUSER_WIDTH_DFLT = 128;

   // Ceiling log2; a ratio of 4 needs a 2-bit lane index.
   function automatic int log2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            r = i + 1;
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

   function automatic bit is_pow2(input int value);
      return (value > 0) && ((value & (value - 1)) == 0);
   endfunction

   // Legal configuration: byte-aligned narrow side, integral power-of-two
   // ratio of at least 2, identical tuser widths on both sides.
   function automatic bit cfg_ok(input int s_w, input int m_w,
                                 input int su_w, input int mu_w);
      int ratio;
      ratio = m_w / s_w;
      return ((s_w % 8) == 0) && (m_w == ratio * s_w) && (ratio >= 2) &&
             is_pow2(ratio) && (su_w == mu_w);
   endfunction

   localparam int RATIO      = C_M_AXIS_DATA_WIDTH_DFLT / C_S_AXIS_DATA_WIDTH_DFLT;
   localparam int LANE_IDX_W = log2(RATIO);

   typedef enum logic [0:0] {
      ST_FILL = 1'b0,
      ST_HOLD = 1'b1
   } pack_state_e;

endpackage

// File: rtl/axis_width_packer_if.sv
// axis_width_packer_if
// AXI4-Stream bundle used on both sides of the packer.
// Signals: tdata, tstrb (byte strobes), tuser (sideband), tvalid, tready, tlast.
// Modports: master drives payload/valid/last and samples ready;
//           slave samples payload/valid/last and drives ready.
interface axis_width_packer_if
   import axis_width_packer_pkg::*;
#(
   parameter int DATA_W = C_S_AXIS_DATA_WIDTH_DFLT,
   parameter int USER_W = C_S_AXIS_TUSER_WIDTH_DFLT
);
   localparam int STRB_W = DATA_W / 8;

   logic [DATA_W-1:0] tdata;
   logic [STRB_W-1:0] tstrb;
   logic [USER_W-1:0] tuser;
   logic              tvalid;
   logic              tready;
   logic              tlast;

   modport master (output tdata, output tstrb, output tuser, output tvalid,
                   output tlast, input tready);
   modport slave  (input tdata, input tstrb, input tuser, input tvalid,
                   input tlast, output tready);
endinterface

// File: rtl/axis_width_packer_out_reg.sv
// axis_pack_out_reg
// Single-entry registered output stage of the packer.
// Ports: clk, rst (sync, active-high); load_i with data/strb/user/last
// inputs captures a new wide word; ready_i drains the held word; *_o are
// the registered m_axis payload and valid. A load in the same cycle as a
// drain replaces the word with no bubble.
module axis_pack_out_reg
   import axis_width_packer_pkg::*;
#(
   parameter int DATA_W = C_M_AXIS_DATA_WIDTH_DFLT,
   parameter int USER_W = C_M_AXIS_TUSER_WIDTH_DFLT
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                load_i,
   input  logic [DATA_W-1:0]   data_i,
   input  logic [DATA_W/8-1:0] strb_i,
   input  logic [USER_W-1:0]   user_i,
   input  logic                last_i,
   input  logic                ready_i,
   output logic                valid_o,
   output logic [DATA_W-1:0]   data_o,
   output logic [DATA_W/8-1:0] strb_o,
   output logic [USER_W-1:0]   user_o,
   output logic                last_o
);
   localparam int STRB_W = DATA_W / 8;

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q,  data_d;
   logic [STRB_W-1:0] strb_q,  strb_d;
   logic [USER_W-1:0] user_q,  user_d;
   logic              last_q,  last_d;

   // Next-state: load wins over drain; payload holds while not reloaded.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      strb_d  = strb_q;
      user_d  = user_q;
      last_d  = last_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
         strb_d  = strb_i;
         user_d  = user_i;
         last_d  = last_i;
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // Output register with synchronous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         strb_q  <= '0;
         user_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         strb_q  <= strb_d;
         user_q  <= user_d;
         last_q  <= last_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign strb_o  = strb_q;
   assign user_o  = user_q;
   assign last_o  = last_q;
endmodule

// File: rtl/axis_width_packer.sv
// axis_width_packer
// Packet-aware AXI4-Stream upsizer: packs RATIO narrow beats into one wide
// beat, little-endian lane order, flushing a partial word on tlast.
// Ports: axi_aclk, axi_reset (sync, active-high); s_axis (narrow slave
// side, tready registered); m_axis (wide master side, registered outputs).
// tuser of the first narrow beat of a packet rides on the first wide beat;
// later wide beats of the same packet carry zero.
module axis_width_packer
   import axis_width_packer_pkg::*;
#(
   parameter int C_S_AXIS_DATA_WIDTH  = C_S_AXIS_DATA_WIDTH_DFLT,
   parameter int C_M_AXIS_DATA_WIDTH  = C_M_AXIS_DATA_WIDTH_DFLT,
   parameter int C_S_AXIS_TUSER_WIDTH = C_S_AXIS_TUSER_WIDTH_DFLT,
   parameter int C_M_AXIS_TUSER_WIDTH = C_M_AXIS_TUSER_WIDTH_DFLT
)(
   input  logic                  axi_aclk,
   input  logic                  axi_reset,
   axis_width_packer_if.slave    s_axis,
   axis_width_packer_if.master   m_axis
);
   localparam int S_W  = C_S_AXIS_DATA_WIDTH;
   localparam int SS_W = S_W / 8;
   localparam int M_W  = C_M_AXIS_DATA_WIDTH;
   localparam int MS_W = M_W / 8;
   localparam int U_W  = C_M_AXIS_TUSER_WIDTH;
   localparam int R    = M_W / S_W;
   localparam int LW   = log2(R);

   if (!cfg_ok(C_S_AXIS_DATA_WIDTH, C_M_AXIS_DATA_WIDTH,
               C_S_AXIS_TUSER_WIDTH, C_M_AXIS_TUSER_WIDTH)) begin : g_cfg_err
      $error("axis_width_packer: illegal width configuration");
   end

   pack_state_e      state_q, state_d;
   logic [LW-1:0]    lane_idx_q, lane_idx_d;
   logic [M_W-1:0]   acc_data_q, acc_data_d;
   logic [MS_W-1:0]  acc_strb_q, acc_strb_d;
   logic [U_W-1:0]   acc_user_q, acc_user_d;
   logic             acc_last_q, acc_last_d;
   logic             first_q, first_d;
   logic             s_ready_q, s_ready_d;

   logic [M_W-1:0]   merged_data_s;
   logic [MS_W-1:0]  merged_strb_s;
   logic [U_W-1:0]   word_user_s;
   logic             accept_s, complete_s, out_free_s, load_s;
   logic [M_W-1:0]   ld_data_s;
   logic [MS_W-1:0]  ld_strb_s;
   logic [U_W-1:0]   ld_user_s;
   logic             ld_last_s;
   logic             out_valid_s, out_last_s;
   logic [M_W-1:0]   out_data_s;
   logic [MS_W-1:0]  out_strb_s;
   logic [U_W-1:0]   out_user_s;

   assign accept_s   = s_axis.tvalid & s_ready_q;
   assign complete_s = (lane_idx_q == LW'(R - 1)) | s_axis.tlast;
   assign out_free_s = ~out_valid_s | m_axis.tready;
   // First beat of a packet supplies tuser; otherwise keep what was captured
   // (zero once the packet's first wide word has been emitted).
   assign word_user_s = first_q ? s_axis.tuser : acc_user_q;

   // Lane merge: drop the incoming beat into its lane of the accumulator.
   always_comb begin
      merged_data_s = acc_data_q;
      merged_strb_s = acc_strb_q;
      for (int k = 0; k < R; k++) begin
         if (lane_idx_q == LW'(k)) begin
            merged_data_s[k*S_W +: S_W]   = s_axis.tdata;
            merged_strb_s[k*SS_W +: SS_W] = s_axis.tstrb;
         end else begin
            merged_data_s[k*S_W +: S_W]   = acc_data_q[k*S_W +: S_W];
            merged_strb_s[k*SS_W +: SS_W] = acc_strb_q[k*SS_W +: SS_W];
         end
      end
   end

   // FSM next-state and output-register load control.
   always_comb begin
      state_d    = state_q;
      lane_idx_d = lane_idx_q;
      acc_data_d = acc_data_q;
      acc_strb_d = acc_strb_q;
      acc_user_d = acc_user_q;
      acc_last_d = acc_last_q;
      first_d    = first_q;
      load_s     = 1'b0;
      ld_data_s  = merged_data_s;
      ld_strb_s  = merged_strb_s;
      ld_user_s  = word_user_s;
      ld_last_s  = s_axis.tlast;
      case (state_q)
         ST_FILL: begin
            if (accept_s) begin
               if (complete_s) begin
                  first_d = s_axis.tlast;
                  if (out_free_s) begin
                     load_s     = 1'b1;
                     lane_idx_d = '0;
                     acc_data_d = '0;
                     acc_strb_d = '0;
                     acc_user_d = '0;
                     acc_last_d = 1'b0;
                  end else begin
                     // Park the finished word until the output drains.
                     acc_data_d = merged_data_s;
                     acc_strb_d = merged_strb_s;
                     acc_user_d = word_user_s;
                     acc_last_d = s_axis.tlast;
                     state_d    = ST_HOLD;
                  end
               end else begin
                  acc_data_d = merged_data_s;
                  acc_strb_d = merged_strb_s;
                  acc_user_d = word_user_s;
                  lane_idx_d = lane_idx_q + LW'(1);
                  first_d    = 1'b0;
               end
            end else begin
               state_d = ST_FILL;
            end
         end
         ST_HOLD: begin
            if (out_free_s) begin
               load_s     = 1'b1;
               ld_data_s  = acc_data_q;
               ld_strb_s  = acc_strb_q;
               ld_user_s  = acc_user_q;
               ld_last_s  = acc_last_q;
               acc_data_d = '0;
               acc_strb_d = '0;
               acc_user_d = '0;
               acc_last_d = 1'b0;
               lane_idx_d = '0;
               state_d    = ST_FILL;
            end else begin
               state_d = ST_HOLD;
            end
         end
         default: begin
            state_d = ST_FILL;
         end
      endcase
      // tready is a flop so it never depends on tvalid/tlast.
      s_ready_d = (state_d == ST_FILL);
   end

   // State, accumulator and lane counter registers.
   always_ff @(posedge axi_aclk) begin
      if (axi_reset) begin
         state_q    <= ST_FILL;
         lane_idx_q <= '0;
         acc_data_q <= '0;
         acc_strb_q <= '0;
         acc_user_q <= '0;
         acc_last_q <= 1'b0;
         first_q    <= 1'b1;
         s_ready_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         lane_idx_q <= lane_idx_d;
         acc_data_q <= acc_data_d;
         acc_strb_q <= acc_strb_d;
         acc_user_q <= acc_user_d;
         acc_last_q <= acc_last_d;
         first_q    <= first_d;
         s_ready_q  <= s_ready_d;
      end
   end

   axis_pack_out_reg #(
      .DATA_W (M_W),
      .USER_W (U_W)
   ) u_out_reg (
      .clk     (axi_aclk),
      .rst     (axi_reset),
      .load_i  (load_s),
      .data_i  (ld_data_s),
      .strb_i  (ld_strb_s),
      .user_i  (ld_user_s),
      .last_i  (ld_last_s),
      .ready_i (m_axis.tready),
      .valid_o (out_valid_s),
      .data_o  (out_data_s),
      .strb_o  (out_strb_s),
      .user_o  (out_user_s),
      .last_o  (out_last_s)
   );

   assign s_axis.tready = s_ready_q;
   assign m_axis.tvalid = out_valid_s;
   assign m_axis.tdata  = out_data_s;
   assign m_axis.tstrb  = out_strb_s;
   assign m_axis.tuser  = out_user_s;
   assign m_axis.tlast  = out_last_s;
endmodule

// File: tb/tb_axis_width_packer.sv
// tb_axis_width_packer
// Directed and randomized stimulus for axis_width_packer with a queue of
// expected wide beats, compared as each wide beat is accepted.
module tb_axis_width_packer;

   typedef struct packed {
      logic [255:0] data;
      logic [31:0]  strb;
      logic [127:0] user;
      logic         last;
   } wide_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   axis_width_packer_if #(.DATA_W(64),  .USER_W(128)) s_if ();
   axis_width_packer_if #(.DATA_W(256), .USER_W(128)) m_if ();

   axis_width_packer #(
      .C_S_AXIS_DATA_WIDTH  (64),
      .C_M_AXIS_DATA_WIDTH  (256),
      .C_S_AXIS_TUSER_WIDTH (128),
      .C_M_AXIS_TUSER_WIDTH (128)
   ) dut (
      .axi_aclk  (clk),
      .axi_reset (rst),
      .s_axis    (s_if),
      .m_axis    (m_if)
   );

   int           n_vec = 0;
   int           n_err = 0;
   bit           rnd_mode = 1'b0;
   wide_t        exp_q[$];
   logic [255:0] mdl_data;
   logic [31:0]  mdl_strb;
   logic [127:0] mdl_user;
   int           mdl_lane;
   bit           mdl_first;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [255:0] d, input logic [31:0] s,
                           input logic [127:0] u, input logic l);
      wide_t w;
      w.data = d; w.strb = s; w.user = u; w.last = l;
      exp_q.push_back(w);
   endtask

   // Reference packer: accumulate lanes, emit on full word or tlast.
   task automatic mdl_reset();
      mdl_data = '0; mdl_strb = '0; mdl_user = '0; mdl_lane = 0; mdl_first = 1'b1;
   endtask

   task automatic mdl_beat(input logic [63:0] d, input logic [7:0] s,
                           input logic [127:0] u, input logic l);
      if (mdl_first) mdl_user = u;
      mdl_data[mdl_lane*64 +: 64] = d;
      mdl_strb[mdl_lane*8 +: 8]   = s;
      if (mdl_lane == 3 || l) begin
         push_exp(mdl_data, mdl_strb, mdl_user, l);
         mdl_data = '0; mdl_strb = '0; mdl_user = '0; mdl_lane = 0;
      end else begin
         mdl_lane++;
      end
      mdl_first = l;
   endtask

   // One clock: note handshakes before the edge, score wide beats after it.
   task automatic step(output bit s_fire);
      bit    m_fire;
      wide_t obs;
      wide_t e;
      if (rnd_mode) m_if.tready = 1'($urandom_range(0, 1));
      m_fire   = m_if.tvalid && m_if.tready;
      s_fire   = s_if.tvalid && s_if.tready;
      obs.data = m_if.tdata; obs.strb = m_if.tstrb;
      obs.user = m_if.tuser; obs.last = m_if.tlast;
      @(posedge clk);
      #1;
      if (m_fire) begin
         chk("out_expected", 256'(exp_q.size() != 0), 256'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("tdata", obs.data, e.data);
            chk("tstrb", 256'(obs.strb), 256'(e.strb));
            chk("tuser", 256'(obs.user), 256'(e.user));
            chk("tlast", 256'(obs.last), 256'(e.last));
         end
      end
   endtask

   task automatic send_beat(input logic [63:0] d, input logic [7:0] s,
                            input logic [127:0] u, input logic l);
      bit f;
      int n;
      f = 1'b0;
      n = 0;
      if (rnd_mode) begin
         while ($urandom_range(0, 1) == 1) begin
            s_if.tvalid = 1'b0;
            step(f);
         end
      end
      s_if.tdata = d; s_if.tstrb = s; s_if.tuser = u; s_if.tlast = l;
      s_if.tvalid = 1'b1;
      f = 1'b0;
      while (!f && n < 500) begin
         step(f);
         n++;
      end
      if (!f) chk("accept_timeout", 256'(f), 256'd1);
   endtask

   task automatic drain(input int maxc);
      bit f;
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < maxc) begin
         step(f);
         n++;
      end
      chk("drain_empty", 256'(exp_q.size()), 256'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      bit           f;
      int           len;
      logic [127:0] u;
      logic [63:0]  d;
      logic [7:0]   st;

      s_if.tdata = '0; s_if.tstrb = '0; s_if.tuser = '0;
      s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
      m_if.tready = 1'b0;
      mdl_reset();

      // Reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_m_tvalid", 256'(m_if.tvalid), 256'd0);
      chk("rst_s_tready", 256'(s_if.tready), 256'd0);
      chk("rst_m_tdata",  m_if.tdata, 256'd0);
      chk("rst_m_tstrb",  256'(m_if.tstrb), 256'd0);
      chk("rst_m_tuser",  256'(m_if.tuser), 256'd0);
      chk("rst_m_tlast",  256'(m_if.tlast), 256'd0);
      rst = 1'b0;
      step(f);
      chk("post_rst_s_tready", 256'(s_if.tready), 256'd1);

      // 8-beat packet, full strobes, output always ready
      m_if.tready = 1'b1;
      push_exp({64'h4, 64'h3, 64'h2, 64'h1}, 32'hFFFF_FFFF, 128'h55, 1'b0);
      push_exp({64'h8, 64'h7, 64'h6, 64'h5}, 32'hFFFF_FFFF, 128'h0,  1'b1);
      for (int i = 1; i <= 8; i++) begin
         send_beat(64'(i), 8'hFF, 128'h55, i == 8);
         if (i == 4) chk("latency_tvalid", 256'(m_if.tvalid), 256'd1);
      end
      s_if.tvalid = 1'b0;
      drain(20);

      // 5-beat packet, partial strobes on the last beat
      push_exp({64'h14, 64'h13, 64'h12, 64'h11}, 32'hFFFF_FFFF, 128'h77, 1'b0);
      push_exp({192'h0, 64'hAAAA_0000_0000_0015}, 32'h0000_000F, 128'h0, 1'b1);
      send_beat(64'h11, 8'hFF, 128'h77, 1'b0);
      send_beat(64'h12, 8'hFF, 128'h77, 1'b0);
      send_beat(64'h13, 8'hFF, 128'h77, 1'b0);
      send_beat(64'h14, 8'hFF, 128'h77, 1'b0);
      send_beat(64'hAAAA_0000_0000_0015, 8'h0F, 128'h77, 1'b1);
      s_if.tvalid = 1'b0;
      drain(20);

      // Single-beat packet followed back-to-back by a 4-beat packet
      push_exp({192'h0, 64'hA1}, 32'h0000_00FF, 128'hABCD, 1'b1);
      push_exp({64'hB4, 64'hB3, 64'hB2, 64'hB1}, 32'hFFFF_FFFF, 128'h1234, 1'b1);
      send_beat(64'hA1, 8'hFF, 128'hABCD, 1'b1);
      send_beat(64'hB1, 8'hFF, 128'h1234, 1'b0);
      send_beat(64'hB2, 8'hFF, 128'h1234, 1'b0);
      send_beat(64'hB3, 8'hFF, 128'h1234, 1'b0);
      send_beat(64'hB4, 8'hFF, 128'h1234, 1'b1);
      s_if.tvalid = 1'b0;
      drain(20);

      // Output back-pressure for 10 cycles across an 8-beat packet
      m_if.tready = 1'b0;
      push_exp({64'h104, 64'h103, 64'h102, 64'h101}, 32'hFFFF_FFFF, 128'h99, 1'b0);
      push_exp({64'h108, 64'h107, 64'h106, 64'h105}, 32'hFFFF_FFFF, 128'h0,  1'b1);
      for (int i = 1; i <= 8; i++) begin
         send_beat(64'(256 + i), 8'hFF, 128'h99, i == 8);
      end
      s_if.tvalid = 1'b0;
      chk("hold_s_tready", 256'(s_if.tready), 256'd0);
      for (int c = 0; c < 2; c++) begin
         step(f);
         chk("hold_m_tvalid", 256'(m_if.tvalid), 256'd1);
         chk("hold_m_tdata", m_if.tdata, {64'h104, 64'h103, 64'h102, 64'h101});
         chk("hold_m_tuser", 256'(m_if.tuser), 256'h99);
         chk("hold_s_tready2", 256'(s_if.tready), 256'd0);
      end
      m_if.tready = 1'b1;
      step(f);
      chk("release_m_tvalid", 256'(m_if.tvalid), 256'd1);
      step(f);
      chk("release_q_empty", 256'(exp_q.size()), 256'd0);
      chk("release_s_tready", 256'(s_if.tready), 256'd1);
      step(f);
      chk("release_idle", 256'(m_if.tvalid), 256'd0);

      // Random packets with random valid/ready
      mdl_reset();
      rnd_mode = 1'b1;
      for (int p = 0; p < 1000; p++) begin
         if ($urandom_range(0, 24) == 0) len = int'($urandom_range(1, 200));
         else len = int'($urandom_range(1, 12));
         u = {$urandom(), $urandom(), $urandom(), $urandom()};
         for (int b = 0; b < len; b++) begin
            d  = {$urandom(), $urandom()};
            st = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom());
            send_beat(d, st, (b == 0) ? u : {$urandom(), $urandom(), 64'h0}, b == len - 1);
            mdl_beat(d, st, (b == 0) ? u : 128'h0, b == len - 1);
         end
      end
      s_if.tvalid = 1'b0;
      drain(5000);
      rnd_mode = 1'b0;

      // Reset mid-packet with an undelivered output word pending
      m_if.tready = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         send_beat(64'(512 + i), 8'hFF, 128'hEE, 1'b0);
      end
      s_if.tvalid = 1'b0;
      rst = 1'b1;
      step(f);
      chk("midrst_m_tvalid", 256'(m_if.tvalid), 256'd0);
      chk("midrst_s_tready", 256'(s_if.tready), 256'd0);
      chk("midrst_m_tdata",  m_if.tdata, 256'd0);
      step(f);
      rst = 1'b0;
      m_if.tready = 1'b1;
      step(f);
      chk("midrst_post_s_tready", 256'(s_if.tready), 256'd1);
      mdl_reset();
      for (int i = 1; i <= 4; i++) begin
         d = 64'(768 + i);
         send_beat(d, 8'hFF, 128'hD0, i == 4);
         mdl_beat(d, 8'hFF, 128'hD0, i == 4);
      end
      s_if.tvalid = 1'b0;
      drain(20);
      for (int c = 0; c < 8; c++) step(f);
      chk("midrst_no_extra", 256'(m_if.tvalid), 256'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
